// File: rtl/console_pkg.sv
// console_pkg: shared defaults, character codes and FSM states for the text console
package console_pkg;
  localparam int DEF_COLS = 40;
  localparam int DEF_ROWS = 8;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] BS    = 8'h08;
  localparam logic [7:0] SPACE = 8'h20;
  typedef enum logic [1:0] {CLR_ALL, IDLE, CLR_ROW} state_t;
endpackage

// File: rtl/uart_text_console_if.sv
// uart_text_console_if: byte stream handshake into the console
// in_data/in_valid flow master->slave, in_ready flows slave->master
interface uart_text_console_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  modport master(output in_data, in_valid, input in_ready);
  modport slave(input in_data, in_valid, output in_ready);
endinterface

// File: rtl/console_char_ram.sv
// console_char_ram: character RAM with one write port and one registered read-before-write read port
// clk: clock; we/waddr/wdata: write port; raddr/rdata: read port, 1-cycle latency
module console_char_ram #(
  parameter int DEPTH = 320,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/uart_text_console.sv
// uart_text_console: scrolling text screen fed by a byte stream, with a random-access character read port
// clk/rst_n: clock and async active-low reset; in_if: byte stream (slave)
// rd_row/rd_col -> rd_char: registered character read; cur_row/cur_col: cursor; clearing: clear sweep active
module uart_text_console import console_pkg::*; #(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  uart_text_console_if.slave      in_if,
  input  logic [$clog2(ROWS)-1:0] rd_row,
  input  logic [$clog2(COLS)-1:0] rd_col,
  output logic [7:0]              rd_char,
  output logic [$clog2(ROWS)-1:0] cur_row,
  output logic [$clog2(COLS)-1:0] cur_col,
  output logic                    clearing
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int AW = $clog2(ROWS * COLS);
  state_t state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] row_q, row_d, top_q, top_d;
  logic [CW-1:0] col_q, col_d;
  logic blank_q, blank_d;
  logic we;
  logic [AW-1:0] waddr;
  logic [7:0] wdata, ram_rdata;
  logic accept, printable, newline, last_row, clr_done;

  function automatic logic [AW-1:0] addr_of(input logic [RW-1:0] prow, input logic [CW-1:0] col);
    return AW'(prow) * AW'(COLS) + AW'(col);
  endfunction

  assign accept    = state_q == IDLE && in_if.in_valid;
  assign printable = in_if.in_data >= 8'h20 && in_if.in_data <= 8'h7E;
  // a printable byte in the last column wraps exactly like an LF
  assign newline   = accept && (in_if.in_data == LF || (printable && col_q == CW'(COLS - 1)));
  assign last_row  = row_q == RW'(ROWS - 1);
  assign clr_done  = cnt_q == (state_q == CLR_ALL ? AW'(ROWS * COLS - 1) : AW'(COLS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLR_ALL;
      cnt_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      top_q   <= '0;
      blank_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
      top_q   <= top_d;
      blank_q <= blank_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    col_d   = col_q;
    top_d   = top_q;
    blank_d = 32'(rd_col) >= COLS;
    if (state_q != IDLE) begin
      cnt_d   = clr_done ? '0 : cnt_q + AW'(1);
      state_d = clr_done ? IDLE : state_q;
    end else if (newline) begin
      col_d = '0;
      if (last_row) begin
        top_d   = top_q + RW'(1);
        state_d = CLR_ROW;
        cnt_d   = '0;
      end else begin
        row_d = row_q + RW'(1);
      end
    end else if (accept) begin
      col_d = printable ? col_q + CW'(1) :
              in_if.in_data == CR ? '0 :
              (in_if.in_data == BS && col_q != '0) ? col_q - CW'(1) : col_q;
    end
  end

  always_comb begin
    in_if.in_ready = state_q == IDLE;
    clearing       = state_q != IDLE;
    we             = state_q != IDLE || (accept && printable);
    wdata          = state_q == IDLE ? in_if.in_data : SPACE;
    // after a scroll top_q already points past the old top row, which is the new bottom row
    waddr          = state_q == CLR_ALL ? cnt_q :
                     state_q == CLR_ROW ? addr_of(top_q + RW'(ROWS - 1), CW'(cnt_q)) :
                     addr_of(top_q + row_q, col_q);
  end

  console_char_ram #(.DEPTH(ROWS * COLS), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (addr_of(top_q + rd_row, rd_col)),
    .rdata (ram_rdata)
  );

  assign rd_char = blank_q ? SPACE : ram_rdata;
  assign cur_row = row_q;
  assign cur_col = col_q;
endmodule
